fetch_unit: RTL and testbench

- Program-counter and fetch stage that drives the address into the instruction ROM.
- Captures the returned 9-bit machine word into an instruction register (IR) and hands it to the decoder over a valid/ready handshake.
- Handles start, branch redirect with flush, halt detection, and PC wrap fault.
- Sits between the top-level start/done control and the decode stage.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/branch_target.sv | 30 +++
 rtl/fetch_unit.sv | 165 ++++++++++++++++
 tb/tb_fetch_unit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage: FSM state encoding,
// instruction/offset widths and the default halt word.
package fetch_pkg;

    localparam int IW  = 9;
    localparam int BOW = 8;

    localparam logic [IW-1:0] HALT_CODE_DEF = 9'b111111111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

endpackage

// File: rtl/branch_target.sv
// Branch target generation: absolute target or ir_pc plus sign-extended
// offset, truncated to the PC width so relative targets wrap silently.
module branch_target
    import fetch_pkg::*;
#(
    parameter int D = 9
) (
    input  logic [D-1:0]   ir_pc,
    input  logic           br_rel,
    input  logic [BOW-1:0] br_off,
    input  logic [D-1:0]   br_abs,
    output logic [D-1:0]   target
);

    logic [D-1:0] off_ext;

    // Offset is fitted to the PC width; narrower PCs simply drop high offset bits.
    generate
        if (D > BOW) begin : g_sext
            assign off_ext = {{(D-BOW){br_off[BOW-1]}}, br_off};
        end else if (D == BOW) begin : g_same
            assign off_ext = br_off;
        end else begin : g_trunc
            assign off_ext = br_off[D-1:0];
        end
    endgenerate

    assign target = br_rel ? (ir_pc + off_ext) : br_abs;

endmodule

// File: rtl/fetch_unit.sv
// PC / fetch stage: drives the ROM address, latches words into IR and hands
// them to decode over valid/ready. Optional perf counters via FETCH_PERF_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int            D          = 9,
    parameter logic [IW-1:0] HALT_CODE  = HALT_CODE_DEF,
    parameter logic [D-1:0]  START_ADDR = '0
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    output logic [D-1:0]   prog_ctr,
    input  logic [IW-1:0]  mach_code,
    output logic [IW-1:0]  ir,
    output logic [D-1:0]   ir_pc,
    output logic           ir_valid,
    input  logic           ir_ready,
    input  logic           br_taken,
    input  logic           br_rel,
    input  logic [BOW-1:0] br_off,
    input  logic [D-1:0]   br_abs,
    output logic           done,
`ifdef FETCH_PERF_EN
    output logic [15:0]    cyc_cnt,
    output logic [15:0]    ret_cnt,
`endif
    output logic           fault
);

    localparam logic [D-1:0] PC_MAX = '1;

    state_t        state_reg, state_next;
    logic [D-1:0]  pc_reg, pc_next;
    logic [IW-1:0] ir_reg, ir_next;
    logic [D-1:0]  ir_pc_reg, ir_pc_next;
    logic          ir_valid_reg, ir_valid_next;
    logic          fault_reg, fault_next;

    logic          handshake;
    logic          redirect;
    logic          advance;
    logic          restart;
    logic [D-1:0]  target;

    branch_target #(.D(D)) u_branch_target (
        .ir_pc  (ir_pc_reg),
        .br_rel (br_rel),
        .br_off (br_off),
        .br_abs (br_abs),
        .target (target)
    );

    assign handshake = ir_valid_reg && ir_ready;
    assign redirect  = handshake && br_taken;
    assign advance   = !ir_valid_reg || ir_ready;
    assign restart   = start && (state_reg != RUN);

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        ir_next       = ir_reg;
        ir_pc_next    = ir_pc_reg;
        ir_valid_next = ir_valid_reg;
        fault_next    = fault_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next    = RUN;
                    pc_next       = START_ADDR;
                    ir_valid_next = 1'b0;
                    fault_next    = 1'b0;
                end
            end
            RUN: begin
                if (redirect) begin
                    pc_next       = target;
                    ir_valid_next = 1'b0;
                end else if (advance) begin
                    ir_next       = mach_code;
                    ir_pc_next    = pc_reg;
                    ir_valid_next = 1'b1;
                    // Halt and wrap both freeze the PC and stop fetching.
                    if (mach_code == HALT_CODE) begin
                        state_next = HALT;
                    end else if (pc_reg == PC_MAX) begin
                        state_next = HALT;
                        fault_next = 1'b1;
                    end else begin
                        pc_next = pc_reg + 1'b1;
                    end
                end
            end
            HALT: begin
                if (start) begin
                    state_next    = RUN;
                    pc_next       = START_ADDR;
                    ir_valid_next = 1'b0;
                    fault_next    = 1'b0;
                end else if (redirect) begin
                    state_next    = RUN;
                    pc_next       = target;
                    ir_valid_next = 1'b0;
                end else if (handshake) begin
                    ir_valid_next = 1'b0;
                end
            end
            default: begin
                state_next    = IDLE;
                ir_valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            pc_reg       <= START_ADDR;
            ir_reg       <= '0;
            ir_pc_reg    <= '0;
            ir_valid_reg <= 1'b0;
            fault_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            ir_reg       <= ir_next;
            ir_pc_reg    <= ir_pc_next;
            ir_valid_reg <= ir_valid_next;
            fault_reg    <= fault_next;
        end
    end

    assign prog_ctr = pc_reg;
    assign ir       = ir_reg;
    assign ir_pc    = ir_pc_reg;
    assign ir_valid = ir_valid_reg;
    assign fault    = fault_reg;
    // Halted with the final word already drained.
    assign done     = (state_reg == HALT) && !ir_valid_reg;

`ifdef FETCH_PERF_EN
    logic [15:0] cyc_cnt_reg;
    logic [15:0] ret_cnt_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc_cnt_reg <= '0;
            ret_cnt_reg <= '0;
        end else if (restart) begin
            cyc_cnt_reg <= '0;
            ret_cnt_reg <= '0;
        end else begin
            if ((state_reg == RUN) && (cyc_cnt_reg != 16'hFFFF))
                cyc_cnt_reg <= cyc_cnt_reg + 16'd1;
            if (handshake && (ret_cnt_reg != 16'hFFFF))
                ret_cnt_reg <= ret_cnt_reg + 16'd1;
        end
    end

    assign cyc_cnt = cyc_cnt_reg;
    assign ret_cnt = ret_cnt_reg;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: table of per-cycle vectors against a
// bench-side ROM, then branch / wrap / async-reset sequences.
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [8:0] prog_ctr;
    logic [8:0] mach_code;
    logic [8:0] ir;
    logic [8:0] ir_pc;
    logic       ir_valid;
    logic       ir_ready;
    logic       br_taken;
    logic       br_rel;
    logic [7:0] br_off;
    logic [8:0] br_abs;
    logic       done;
    logic       fault;
`ifdef FETCH_PERF_EN
    logic [15:0] cyc_cnt;
    logic [15:0] ret_cnt;
`endif

    logic [8:0] rom [512];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign mach_code = rom[prog_ctr];

    fetch_unit #(.D(9)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .prog_ctr  (prog_ctr),
        .mach_code (mach_code),
        .ir        (ir),
        .ir_pc     (ir_pc),
        .ir_valid  (ir_valid),
        .ir_ready  (ir_ready),
        .br_taken  (br_taken),
        .br_rel    (br_rel),
        .br_off    (br_off),
        .br_abs    (br_abs),
        .done      (done),
`ifdef FETCH_PERF_EN
        .cyc_cnt   (cyc_cnt),
        .ret_cnt   (ret_cnt),
`endif
        .fault     (fault)
    );

    typedef struct {
        logic       st;
        logic       rdy;
        logic       bt;
        logic       brel;
        logic [7:0] boff;
        logic [8:0] babs;
        logic       e_valid;
        logic [8:0] e_irpc;
        logic [8:0] e_pc;
        logic       e_done;
        logic       e_fault;
    } vec_t;

    function automatic vec_t mk(logic st, logic rdy, logic bt, logic brel,
                                logic [7:0] boff, logic [8:0] babs,
                                logic ev, logic [8:0] eirpc, logic [8:0] epc,
                                logic edone, logic efault);
        vec_t v;
        v.st = st; v.rdy = rdy; v.bt = bt; v.brel = brel;
        v.boff = boff; v.babs = babs;
        v.e_valid = ev; v.e_irpc = eirpc; v.e_pc = epc;
        v.e_done = edone; v.e_fault = efault;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs, clock, then compare 1 time unit after the edge.
    task automatic do_step(input vec_t v, input string tag);
        start    = v.st;
        ir_ready = v.rdy;
        br_taken = v.bt;
        br_rel   = v.brel;
        br_off   = v.boff;
        br_abs   = v.babs;
        @(posedge clk);
        #1;
        $display("step %s irv=%0b ir_pc=%0d ir=%0h pc=%0d done=%0b fault=%0b",
                 tag, ir_valid, ir_pc, ir, prog_ctr, done, fault);
        chk({tag, ".ir_valid"}, 32'(ir_valid), 32'(v.e_valid));
        chk({tag, ".prog_ctr"}, 32'(prog_ctr), 32'(v.e_pc));
        chk({tag, ".done"},     32'(done),     32'(v.e_done));
        chk({tag, ".fault"},    32'(fault),    32'(v.e_fault));
        if (v.e_valid) begin
            chk({tag, ".ir_pc"}, 32'(ir_pc), 32'(v.e_irpc));
            chk({tag, ".ir"},    32'(ir),    32'(rom[v.e_irpc]));
        end
    endtask

    vec_t vecs [17];
    vec_t v;

    initial begin
        for (int i = 0; i < 512; i++) rom[i] = {1'b0, 8'(i)};
        rom[5] = 9'h1FF;
        rom[8] = 9'h1FF;

        // Straight line to halt at 5, then restart and stall at ir_pc=2.
        vecs[0]  = mk(1, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 1, 0, 0, 0, 0,   1, 0, 1, 0, 0);
        vecs[2]  = mk(0, 1, 0, 0, 0, 0,   1, 1, 2, 0, 0);
        vecs[3]  = mk(0, 1, 0, 0, 0, 0,   1, 2, 3, 0, 0);
        vecs[4]  = mk(0, 1, 0, 0, 0, 0,   1, 3, 4, 0, 0);
        vecs[5]  = mk(0, 1, 0, 0, 0, 0,   1, 4, 5, 0, 0);
        vecs[6]  = mk(0, 1, 0, 0, 0, 0,   1, 5, 5, 0, 0);
        vecs[7]  = mk(0, 1, 0, 0, 0, 0,   0, 0, 5, 1, 0);
        vecs[8]  = mk(0, 1, 0, 0, 0, 0,   0, 0, 5, 1, 0);
        vecs[9]  = mk(1, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        vecs[10] = mk(0, 1, 0, 0, 0, 0,   1, 0, 1, 0, 0);
        vecs[11] = mk(0, 1, 0, 0, 0, 0,   1, 1, 2, 0, 0);
        vecs[12] = mk(0, 1, 0, 0, 0, 0,   1, 2, 3, 0, 0);
        vecs[13] = mk(0, 0, 0, 0, 0, 0,   1, 2, 3, 0, 0);
        vecs[14] = mk(0, 0, 1, 0, 0, 99,  1, 2, 3, 0, 0);
        vecs[15] = mk(1, 0, 0, 0, 0, 0,   1, 2, 3, 0, 0);
        vecs[16] = mk(0, 1, 0, 0, 0, 0,   1, 3, 4, 0, 0);

        reset_n = 1'b0; start = 0; ir_ready = 0; br_taken = 0;
        br_rel = 0; br_off = '0; br_abs = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.ir_valid", 32'(ir_valid), 0);
        chk("rst.prog_ctr", 32'(prog_ctr), 0);
        chk("rst.ir",       32'(ir),       0);
        chk("rst.done",     32'(done),     0);
        chk("rst.fault",    32'(fault),    0);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle.ir_valid", 32'(ir_valid), 0);

        for (int i = 0; i < 17; i++) begin
            do_step(vecs[i], $sformatf("v%0d", i));
`ifdef FETCH_PERF_EN
            if (i == 8) begin
                chk("perf.cyc_cnt", 32'(cyc_cnt), 6);
                chk("perf.ret_cnt", 32'(ret_cnt), 6);
            end
`endif
        end

        // Absolute branch, relative back, branch over a halt fetch.
        do_step(mk(0, 1, 1, 0, 8'h00, 9'd10,  0, 0, 10, 0, 0), "abs10");
        do_step(mk(0, 1, 0, 0, 8'h00, 9'd0,   1, 10, 11, 0, 0), "f10");
        do_step(mk(0, 1, 1, 1, 8'hFC, 9'd0,   0, 0, 6, 0, 0), "rel-4");
        do_step(mk(0, 1, 0, 0, 8'h00, 9'd0,   1, 6, 7, 0, 0), "f6");
        do_step(mk(0, 1, 0, 0, 8'h00, 9'd0,   1, 7, 8, 0, 0), "f7");
        do_step(mk(0, 1, 1, 0, 8'h00, 9'd20,  0, 0, 20, 0, 0), "abs20_over_halt");
        do_step(mk(0, 1, 0, 0, 8'h00, 9'd0,   1, 20, 21, 0, 0), "f20");
        // Relative forward wrap: 500 + 127 = 115 mod 512, no fault.
        do_step(mk(0, 1, 1, 0, 8'h00, 9'd500, 0, 0, 500, 0, 0), "abs500");
        do_step(mk(0, 1, 0, 0, 8'h00, 9'd0,   1, 500, 501, 0, 0), "f500");
        do_step(mk(0, 1, 1, 1, 8'h7F, 9'd0,   0, 0, 115, 0, 0), "rel+127");
        do_step(mk(0, 1, 0, 0, 8'h00, 9'd0,   1, 115, 116, 0, 0), "f115");
        // PC wrap fault at 511, then start clears it.
        do_step(mk(0, 1, 1, 0, 8'h00, 9'd511, 0, 0, 511, 0, 0), "abs511");
        do_step(mk(0, 0, 0, 0, 8'h00, 9'd0,   1, 511, 511, 0, 1), "f511");
        do_step(mk(0, 1, 0, 0, 8'h00, 9'd0,   0, 0, 511, 1, 1), "drain511");
        do_step(mk(1, 1, 0, 0, 8'h00, 9'd0,   0, 0, 0, 0, 0), "restart");
        do_step(mk(0, 1, 0, 0, 8'h00, 9'd0,   1, 0, 1, 0, 0), "f0");
        do_step(mk(0, 0, 0, 0, 8'h00, 9'd0,   1, 0, 1, 0, 0), "stall0");

        // Async reset mid-stall, checked before any further clock edge.
        #2 reset_n = 1'b0;
        #1;
        $display("step async_rst irv=%0b ir_pc=%0d ir=%0h pc=%0d done=%0b fault=%0b",
                 ir_valid, ir_pc, ir, prog_ctr, done, fault);
        chk("arst.ir_valid", 32'(ir_valid), 0);
        chk("arst.ir",       32'(ir),       0);
        chk("arst.ir_pc",    32'(ir_pc),    0);
        chk("arst.prog_ctr", 32'(prog_ctr), 0);
        chk("arst.done",     32'(done),     0);
        chk("arst.fault",    32'(fault),    0);
`ifdef FETCH_PERF_EN
        chk("arst.cyc_cnt",  32'(cyc_cnt),  0);
        chk("arst.ret_cnt",  32'(ret_cnt),  0);
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("arst_hold.ir_valid", 32'(ir_valid), 0);
        chk("arst_hold.prog_ctr", 32'(prog_ctr), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
